// File: rtl/board_load_engine.sv
// Copies one board image from ROM into object memory (or clears it) after a grant handshake.
// Optional clear mode is compiled in with BOARD_LOAD_CLEAR_MODE_EN.
module board_load_engine #(
  parameter int NUM_BOARDS  = 8,
  parameter int BOARD_WORDS = 104,
  parameter int ROM_STRIDE  = 128,
  parameter int ROM_AW      = 10,
  parameter int OM_AW       = 7,
  parameter int DATA_W      = 11
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_key,
  input  logic [$clog2(NUM_BOARDS)-1:0] board_sel,
  input  logic                          mode,
  output logic                          game_request,
  input  logic                          game_grant,
  output logic [ROM_AW-1:0]             rom_addr,
  input  logic [7:0]                    rom_data,
  output logic [OM_AW-1:0]              om_addr,
  output logic [DATA_W-1:0]             om_data,
  output logic                          om_wren,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state_dbg
);

  localparam int SEL_W = $clog2(NUM_BOARDS);
  localparam int CNT_W = $clog2(BOARD_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_GRANT = 2'd1,
    PRIME      = 2'd2,
    COPY       = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               key_q;
  logic               pwrup_q;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               wren_q, wren_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic [OM_AW-1:0]   om_addr_q, om_addr_d;
  logic [DATA_W-1:0]  om_data_q, om_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_clamped;
  logic [ROM_AW-1:0]  base;
  logic [10:0]        raw;
  logic [DATA_W-1:0]  dec;
  logic               rise;

`ifdef BOARD_LOAD_CLEAR_MODE_EN
  logic clr_q, clr_d;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    sel_clamped = (32'(board_sel) >= NUM_BOARDS) ? SEL_W'(NUM_BOARDS - 1) : board_sel;
    base        = ROM_AW'(32'(sel_clamped) * ROM_STRIDE);
    raw         = rom_data[7] ? {4'b0, rom_data[6:0]} : {rom_data[2:0], 8'h00};
    dec         = DATA_W'(raw);
    rise        = start_key & ~key_q;
  end

  // COPY runs one cycle past the last capture so busy covers the final write.
  always_comb begin
    state_d    = state_q;
    req_d      = 1'b0;
    done_d     = 1'b0;
    wren_d     = 1'b0;
    rom_addr_d = rom_addr_q;
    om_addr_d  = om_addr_q;
    om_data_d  = om_data_q;
    cnt_d      = cnt_q;
`ifdef BOARD_LOAD_CLEAR_MODE_EN
    clr_d      = clr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pwrup_q || (rise && !done_q)) begin
          req_d   = 1'b1;
          state_d = WAIT_GRANT;
        end
      end
      WAIT_GRANT: begin
        if (game_grant) begin
          rom_addr_d = base;
          cnt_d      = '0;
`ifdef BOARD_LOAD_CLEAR_MODE_EN
          clr_d      = mode;
`endif
          state_d    = PRIME;
        end
      end
      PRIME: begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = COPY;
      end
      COPY: begin
        rom_addr_d = rom_addr_q + 1'b1;
        if (cnt_q != CNT_W'(BOARD_WORDS)) begin
          wren_d    = 1'b1;
          om_addr_d = OM_AW'(cnt_q);
          om_data_d = dec;
`ifdef BOARD_LOAD_CLEAR_MODE_EN
          if (clr_q) om_data_d = '0;
`endif
          cnt_d     = cnt_q + 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      key_q      <= 1'b0;
      pwrup_q    <= 1'b1;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      wren_q     <= 1'b0;
      rom_addr_q <= '0;
      om_addr_q  <= '0;
      om_data_q  <= '0;
      cnt_q      <= '0;
`ifdef BOARD_LOAD_CLEAR_MODE_EN
      clr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      key_q      <= start_key;
      pwrup_q    <= 1'b0;
      req_q      <= req_d;
      done_q     <= done_d;
      wren_q     <= wren_d;
      rom_addr_q <= rom_addr_d;
      om_addr_q  <= om_addr_d;
      om_data_q  <= om_data_d;
      cnt_q      <= cnt_d;
`ifdef BOARD_LOAD_CLEAR_MODE_EN
      clr_q      <= clr_d;
`endif
    end
  end

  assign game_request = req_q;
  assign rom_addr     = rom_addr_q;
  assign om_addr      = om_addr_q;
  assign om_data      = om_data_q;
  assign om_wren      = wren_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_board_load_engine.sv
// Directed bench for board_load_engine with a 1024-byte ROM model and NUM_BOARDS = 6.
module tb_board_load_engine;

  localparam int BW = 104;
`ifdef BOARD_LOAD_CLEAR_MODE_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_key;
  logic [2:0]  board_sel;
  logic        mode;
  logic        game_request;
  logic        game_grant;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [6:0]  om_addr;
  logic [10:0] om_data;
  logic        om_wren;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rom [1024];
  logic [10:0] wr_data [BW];

  board_load_engine #(
    .NUM_BOARDS (6),
    .BOARD_WORDS(BW),
    .ROM_STRIDE (128),
    .ROM_AW     (10),
    .OM_AW      (7),
    .DATA_W     (11)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_key   (start_key),
    .board_sel   (board_sel),
    .mode        (mode),
    .game_request(game_request),
    .game_grant  (game_grant),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .om_addr     (om_addr),
    .om_data     (om_data),
    .om_wren     (om_wren),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [10:0] dec(input logic [7:0] b);
    if (b >= 8'd128) return 11'(b - 8'd128);
    return 11'((b % 8) * 256);
  endfunction

  // Grant is asserted gd cycles after the caller's current negedge; rel counts cycles after grant.
  task automatic do_copy(input int gd, input logic [2:0] sel, input logic md, input int base,
                         input bit inject, input string nm);
    logic        exp_w, exp_done, exp_busy;
    logic [9:0]  exp_ra;
    logic [10:0] exp_d;
    int          k;
    repeat (gd) @(posedge clk);
    #1; board_sel = sel; mode = md; game_grant = 1'b1;
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++; $display("FAIL %s grant_state: got %0d expected 1", nm, state_dbg);
    end
    @(posedge clk);
    #1; game_grant = 1'b0; board_sel = 3'd0; mode = 1'b0;
    for (int rel = 1; rel <= BW + 6; rel++) begin
      @(negedge clk);
      exp_w    = (rel >= 3) && (rel <= BW + 2);
      exp_done = (rel == BW + 3);
      exp_busy = (rel <= BW + 2);
      checks++;
      if (om_wren !== exp_w || done !== exp_done || busy !== exp_busy || game_request !== 1'b0) begin
        errors++;
        $display("FAIL %s ctl rel=%0d: wren=%b done=%b busy=%b req=%b expected wren=%b done=%b busy=%b req=0",
                 nm, rel, om_wren, done, busy, game_request, exp_w, exp_done, exp_busy);
      end
      if (rel <= BW + 2) begin
        exp_ra = 10'((base + rel - 1) % 1024);
        checks++;
        if (rom_addr !== exp_ra) begin
          errors++; $display("FAIL %s rom_addr rel=%0d: got %0d expected %0d", nm, rel, rom_addr, exp_ra);
        end
      end
      if (exp_w) begin
        k = rel - 3;
        exp_d = (CLR_EN && md) ? 11'd0 : dec(rom[(base + k) % 1024]);
        wr_data[k] = om_data;
        checks++;
        if (om_addr !== 7'(k) || om_data !== exp_d) begin
          errors++;
          $display("FAIL %s write %0d: addr=%0d data=%h expected addr=%0d data=%h", nm, k, om_addr, om_data, k, exp_d);
        end
      end
      if (rel == BW + 4) begin
        checks++;
        if (state_dbg !== 2'd0) begin
          errors++; $display("FAIL %s end_state: got %0d expected 0", nm, state_dbg);
        end
      end
      if (inject) begin
        if (rel == 50)     start_key = 1'b1;
        if (rel == 51)     start_key = 1'b0;
        if (rel == BW + 3) start_key = 1'b1;
        if (rel == BW + 4) start_key = 1'b0;
      end
    end
  endtask

  task automatic req_by_key(input string nm);
    start_key = 1'b1;
    @(negedge clk);
    checks++;
    if (game_request !== 1'b1 || state_dbg !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL %s req_pulse: req=%b state=%0d busy=%b expected 1/1/1", nm, game_request, state_dbg, busy);
    end
    start_key = 1'b0;
    @(negedge clk);
    checks++;
    if (game_request !== 1'b0 || state_dbg !== 2'd1) begin
      errors++; $display("FAIL %s req_single: req=%b state=%0d expected 0/1", nm, game_request, state_dbg);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_key = 1'b0; game_grant = 1'b0; board_sel = 3'd0; mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'd0 || om_wren !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || game_request !== 1'b0 ||
        rom_addr !== 10'd0 || om_addr !== 7'd0 || om_data !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: st=%0d wren=%b done=%b busy=%b req=%b ra=%0d oa=%0d od=%h expected all 0",
               state_dbg, om_wren, done, busy, game_request, rom_addr, om_addr, om_data);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (game_request !== 1'b1 || state_dbg !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL powerup_req: req=%b state=%0d busy=%b expected 1/1/1", game_request, state_dbg, busy);
    end
    @(negedge clk);
    checks++;
    if (game_request !== 1'b0 || state_dbg !== 2'd1) begin
      errors++; $display("FAIL powerup_single: req=%b state=%0d expected 0/1", game_request, state_dbg);
    end
  endtask

  task automatic test_load_board0();
    do_copy(1, 3'd0, 1'b0, 0, 1'b0, "load_board0");
  endtask

  task automatic test_idle_grant();
    game_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (state_dbg !== 2'd0 || om_wren !== 1'b0 || game_request !== 1'b0) begin
        errors++; $display("FAIL idle_grant: state=%0d wren=%b req=%b expected 0/0/0", state_dbg, om_wren, game_request);
      end
    end
    game_grant = 1'b0;
  endtask

  task automatic test_decode_board5();
    req_by_key("decode_board5");
    do_copy(1, 3'd5, 1'b0, 640, 1'b0, "decode_board5");
    checks++;
    if (wr_data[0] !== 11'h005) begin
      errors++; $display("FAIL decode_w0: got %h expected 005", wr_data[0]);
    end
    checks++;
    if (wr_data[1] !== 11'h300) begin
      errors++; $display("FAIL decode_w1: got %h expected 300", wr_data[1]);
    end
  endtask

  task automatic test_clamp();
    req_by_key("clamp_sel7");
    do_copy(1, 3'd7, 1'b0, 640, 1'b0, "clamp_sel7");
  endtask

  task automatic test_clear_mode();
    req_by_key("clear_mode");
    do_copy(2, 3'd2, 1'b1, 256, 1'b0, "clear_mode");
  endtask

  task automatic test_key_ignore();
    req_by_key("key_ignore");
    do_copy(1, 3'd3, 1'b0, 384, 1'b1, "key_ignore");
    req_by_key("key_later");
    do_copy(1, 3'd1, 1'b0, 128, 1'b0, "key_later");
  endtask

  task automatic test_reset_abort();
    req_by_key("reset_abort");
    @(posedge clk);
    #1; board_sel = 3'd4; game_grant = 1'b1;
    @(posedge clk);
    #1; game_grant = 1'b0;
    for (int rel = 1; rel <= 53; rel++) @(negedge clk);
    checks++;
    if (om_wren !== 1'b1 || om_addr !== 7'd50 || om_data !== dec(rom[512 + 50])) begin
      errors++; $display("FAIL abort_w50: wren=%b addr=%0d data=%h expected 1/50/%h", om_wren, om_addr, om_data, dec(rom[562]));
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (om_wren !== 1'b0 || state_dbg !== 2'd0 || busy !== 1'b0 || game_request !== 1'b0) begin
        errors++; $display("FAIL abort_hold %0d: wren=%b state=%0d busy=%b req=%b expected 0/0/0/0", i, om_wren, state_dbg, busy, game_request);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (game_request !== 1'b1 || state_dbg !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_req: req=%b state=%0d busy=%b expected 1/1/1", game_request, state_dbg, busy);
    end
    @(negedge clk);
    checks++;
    if (game_request !== 1'b0) begin
      errors++; $display("FAIL abort_req_single: req=%b expected 0", game_request);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'((i * 73 + 29) ^ (i >> 3));
    rom[640] = 8'h85;
    rom[641] = 8'h03;
    test_reset();
    test_load_board0();
    test_idle_grant();
    test_decode_board5();
    test_clamp();
    test_clear_mode();
    test_key_ignore();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_load_engine.md
BOARD_LOAD_ENGINE -- requirements
Module: board_load_engine

Interface
REQ-001 SHALL have parameter NUM_BOARDS, default 8, number of stored boards.
REQ-002 SHALL have parameter BOARD_WORDS, default 104, object-memory words per board.
REQ-003 SHALL have parameter ROM_STRIDE, default 128, ROM bytes reserved per board.
REQ-004 SHALL have parameter ROM_AW, default 10, ROM address width.
REQ-005 SHALL have parameter OM_AW, default 7, object-memory address width.
REQ-006 SHALL have parameter DATA_W, default 11, object-memory data width.
REQ-007 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_key  in  1  active-high level; rising edge detected internally.
- board_sel  in  $clog2(NUM_BOARDS)  board index.
- mode  in  1  0 = load board, 1 = clear.
- game_request  out  1  one-cycle pulse.
- game_grant  in  1  level.
- rom_addr  out  ROM_AW  ROM read address.
- rom_data  in  8  ROM byte, valid one cycle after its rom_addr.
- om_addr  out  OM_AW  object-memory write address.
- om_data  out  DATA_W  object-memory write data.
- om_wren  out  1  write enable.
- busy  out  1  high from request to completion.
- done  out  1  one-cycle completion pulse.
- state_dbg  out  2  current state encoding.

Function
REQ-008 SHALL implement four states: IDLE = 0, WAIT_GRANT = 1, PRIME = 2, COPY = 3, with state_dbg equal to the current state.
REQ-009 SHALL, in IDLE, on a start_key rising edge, pulse game_request for one cycle and enter WAIT_GRANT; in all other states start_key edges SHALL be ignored and not queued.
REQ-010 SHALL, in WAIT_GRANT, on game_grant = 1:
- latch board_sel and mode;
- set rom_addr = latched_sel * ROM_STRIDE;
- enter PRIME.
game_grant outside WAIT_GRANT SHALL be ignored.
REQ-011 SHALL clamp any board_sel >= NUM_BOARDS to NUM_BOARDS-1 at latch time.
REQ-012 SHALL increment rom_addr by 1 every cycle in PRIME and COPY, wrapping modulo 2^ROM_AW.
REQ-013 SHALL decode each ROM byte b as:
- if b[7] = 1: data = b[6:0], zero-extended to DATA_W;
- if b[7] = 0: data = b[2:0] << 8.
Result bits above DATA_W SHALL be truncated.
REQ-014 SHALL register om_data, om_addr and om_wren. Grant accepted in cycle G SHALL produce:
- om_wren = 1 in cycles G+3 through G+2+BOARD_WORDS inclusive;
- om_addr = k and om_data = decode(ROM byte base+k) in write k (k = 0..BOARD_WORDS-1).
REQ-015 SHALL, in clear mode, drive om_data = 0 with identical addresses and timing.
REQ-016 SHALL deassert om_wren in the cycle after the last write, pulse done for that one cycle, and return to IDLE.
REQ-017 SHALL hold busy = 1 from the game_request cycle through the last write cycle, and 0 otherwise.
REQ-018 SHALL, if start_key rises in the same cycle as done, ignore that edge.

Reset
REQ-019 SHALL, while reset = 1 at a clk edge:
- drive state IDLE;
- drive om_wren, done, busy and game_request to 0;
- drive rom_addr, om_addr and om_data to 0;
- clear the edge-detector history.
REQ-020 SHALL, in the first cycle after reset deasserts, pulse game_request automatically, set busy, and enter WAIT_GRANT. This is the power-up new game, using the current board_sel.
REQ-021 SHALL, on reset asserted during COPY, abort the copy with no further writes; object-memory contents are then undefined.

Configuration
REQ-022 SHALL compile clear mode only when macro BOARD_LOAD_CLEAR_MODE_EN is defined. When it is undefined, mode SHALL be ignored and every operation SHALL be a load.

Verification
REQ-023 SHALL be covered by these directed scenarios:
- Reset release, then grant 2 cycles later, board_sel = 0 -> 104 writes at om_addr 0..103 from ROM 0..103, then one done pulse.
- board_sel = 5 with ROM[640] = 8'h85 and ROM[641] = 8'h03 -> write 0 data = 11'h005, write 1 data = 11'h300.
- board_sel = 7 with NUM_BOARDS = 6 -> base rom_addr = 640 (clamped to board 5).
- Macro defined, mode = 1 -> 104 writes all of data 0, same timing as a load. Macro undefined, mode = 1 -> load data written.
- start_key pulses during COPY and on the done cycle -> no game_request. A later pulse in IDLE -> one game_request.
- Reset asserted at write 50 -> om_wren = 0 next cycle, state_dbg = 0 while reset is held, then an automatic game_request after release.
